display_scanner: RTL

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 126 ++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//   Time-multiplexed scanner for a 4-digit, 7-segment display with a common
//   anode per digit. Each digit is driven for REFRESH_DIV clock cycles, in the
//   order 0 (rightmost), 1, 2, 3. Every input is captured into a snapshot at
//   the end of a full scan frame, so the image stays stable within a frame.
//   Every BLINK_FRAMES frames the blink phase toggles. During the "off"
//   phase, digits that request blinking are blanked.
//
//   Parameters
//     REFRESH_DIV  : cycles each digit is driven (>= 2)
//     BLINK_FRAMES : full frames per blink half-period (>= 1)
//
//   Optional feature
//     LEADING_ZERO_BLANK_EN : when defined, leading zero digits (3..1) are
//                             blanked. Digit 0 is always shown.
//
//   Ports
//     clk        in   system clock, rising edge
//     rst_n      in   synchronous active-low reset
//     digits     in   [15:0] four 4-bit codes, [3:0] = digit 0
//     digit_en   in   [3:0]  per-digit enable (0 = blank)
//     blink_mask in   [3:0]  per-digit blink request
//     dp_in      in   [3:0]  per-digit decimal point request (active-high)
//     anode      out  [3:0]  digit select, active-low one-hot
//     seg_val    out  [3:0]  code of the selected digit
//     seg_en     out         decoder enable
//     dp_n       out         decimal point drive, active-low
// ---------------------------------------------------------------------------
module display_scanner #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode,
  output logic [3:0]  seg_val,
  output logic        seg_en,
  output logic        dp_n
);

  localparam int unsigned TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [TW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [FW-1:0] fcnt_r;
  logic          blink_phase_r;
  logic [15:0]   snap_digits_r;
  logic [3:0]    snap_en_r;
  logic [3:0]    snap_blink_r;
  logic [3:0]    snap_dp_r;

  logic          tick_s;
  logic          frame_end_s;
  logic          frame_wrap_s;
  logic [3:0]    lz_blank_s;

  assign tick_s       = (cnt_r == TW'(REFRESH_DIV - 1));
  assign frame_end_s  = tick_s && (idx_r == 2'd3);
  assign frame_wrap_s = (fcnt_r == FW'(BLINK_FRAMES - 1));

  // Tick counter and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
      idx_r <= 2'd0;
    end else if (tick_s) begin
      cnt_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      cnt_r <= cnt_r + TW'(1);
    end
  end

  // Frame counter, blink phase and input snapshot (updated only at frame end)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_r        <= '0;
      blink_phase_r <= 1'b0;
      snap_digits_r <= 16'h0000;
      snap_en_r     <= 4'b0000;
      snap_blink_r  <= 4'b0000;
      snap_dp_r     <= 4'b0000;
    end else if (frame_end_s) begin
      snap_digits_r <= digits;
      snap_en_r     <= digit_en;
      snap_blink_r  <= blink_mask;
      snap_dp_r     <= dp_in;
      if (frame_wrap_s) begin
        fcnt_r        <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        fcnt_r        <= fcnt_r + FW'(1);
      end
    end
  end

  // Leading-zero mask: digit k is blanked when digits k..3 are all zero
  always_comb begin
    lz_blank_s = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank_s[3] = (snap_digits_r[15:12] == 4'h0);
    lz_blank_s[2] = lz_blank_s[3] && (snap_digits_r[11:8] == 4'h0);
    lz_blank_s[1] = lz_blank_s[2] && (snap_digits_r[7:4] == 4'h0);
`else
    lz_blank_s = 4'b0000;
`endif
  end

  // Output decode; depends on registered state only
  always_comb begin
    anode        = 4'b1111;
    anode[idx_r] = 1'b0;
    seg_val      = snap_digits_r[{idx_r, 2'b00} +: 4];
    seg_en       = snap_en_r[idx_r]
                   && !(snap_blink_r[idx_r] && blink_phase_r)
                   && !lz_blank_s[idx_r];
    dp_n         = ~snap_dp_r[idx_r];
  end

endmodule
